seq_match_counter: RTL and testbench

- Parametrised successor to the single-pattern serial FSM block: a serial bit-stream pattern detector with a programmable pattern width and value, a selectable overlap mode, an input-enable, and a match counter whose width and wrap/saturate policy are set by parameters.
- Sits on a 1-bit serial input (x) driven by the stimulus/source logic.
- Emits a registered one-cycle match pulse and a running match count y for downstream status/display logic.

---
 rtl/seq_match_counter_pkg.sv | 16 +
 rtl/seq_match_counter_if.sv | 40 ++++
 rtl/seq_match_counter_sat_counter.sv | 36 +++
 rtl/seq_match_counter.sv | 72 +++++++
 tb/tb_seq_match_counter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_match_counter_pkg.sv
// Shared constants and helpers for the serial pattern match counter.
// The default pattern/width/counter constants are shared by the design,
// its stimulus source and the bench so all three agree on one pattern.
package seq_pkg;

    localparam int                   DEF_PAT_W    = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN  = 4'b1011;
    localparam int                   DEF_CNT_W    = 3;
    localparam bit                   DEF_SATURATE = 1'b1;

    // Width needed to hold a fill count in the range 0..patW inclusive.
    function automatic int fillWidth(input int patW);
        return $clog2(patW + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter_if.sv
// Bundle of the serial input controls and the match/status outputs.
// The source block drives through 'master'; the detector sits on 'slave'.
interface seq_match_counter_if
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
);

    localparam int FILL_W = fillWidth(PAT_W);

    logic              en;
    logic              x;
    logic              overlap;
    logic              clr;
    logic              match;
    logic [CNT_W-1:0]  y;
    logic [FILL_W-1:0] fill;

    modport master (
        output en,
        output x,
        output overlap,
        output clr,
        input  match,
        input  y,
        input  fill
    );

    modport slave (
        input  en,
        input  x,
        input  overlap,
        input  clr,
        output match,
        output y,
        output fill
    );

endinterface

// File: rtl/seq_match_counter_sat_counter.sv
// Event counter with a synchronous clear and a build-time choice between
// saturating at all-ones and wrapping to zero. An increment arriving in the
// same cycle as a clear is not lost: the count restarts at one.
module sat_counter #(
    parameter int CNT_W    = 3,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;

    // Count events, with clear taking priority but still honouring a same-cycle event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            if (SATURATE && (count_q == CNT_MAX)) begin
                count_q <= count_q;
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_match_counter.sv
// Serial bit-stream pattern detector with programmable pattern, optional
// overlapping matches, input enable and a saturating/wrapping match counter.
// The shift register plus the fill counter are the whole detector state.
module seq_match_counter
    import seq_pkg::*;
#(
    parameter int               PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN  = DEF_PATTERN,
    parameter int               CNT_W    = DEF_CNT_W,
    parameter bit               SATURATE = DEF_SATURATE
) (
    input  logic               clk,
    input  logic               rst,
    seq_match_counter_if.slave bus
);

    localparam int              FILL_W    = fillWidth(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  shreg_q;
    logic [PAT_W-1:0]  shreg_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fillInc;
    logic              match_q;
    logic              hit;
    logic [CNT_W-1:0]  count;

    // Next history/fill and the match decision for the bit presented this cycle.
    always_comb begin
        shreg_d = shreg_q;
        fillInc = fill_q;
        fill_d  = fill_q;
        hit     = 1'b0;
        if (bus.en) begin
            shreg_d = {shreg_q[PAT_W-2:0], bus.x};
            fillInc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
            hit     = (fillInc == FILL_FULL) && (shreg_d == PATTERN);
            // Without overlap the next match must be built from fresh bits only.
            fill_d  = (hit && !bus.overlap) ? '0 : fillInc;
        end
    end

    // Register the history, fill level and the one-cycle match pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            match_q <= hit;
        end
    end

    sat_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
    ) u_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (bus.clr),
        .count (count)
    );

    assign bus.match = match_q;
    assign bus.y     = count;
    assign bus.fill  = fill_q;

endmodule

// File: tb/tb_seq_match_counter.sv
// Bench for seq_match_counter: one saturating and one wrapping instance fed
// the same stream, checked against a queue-based model of the match rules.
module tb_seq_match_counter;
    import seq_pkg::*;

    localparam int               PAT_W   = DEF_PAT_W;
    localparam logic [PAT_W-1:0] PATTERN = DEF_PATTERN;
    localparam int               CNT_W   = DEF_CNT_W;
    localparam int               CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    seq_match_counter_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) busS ();
    seq_match_counter_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) busW ();

    seq_match_counter #(
        .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W), .SATURATE(1'b1)
    ) dutSat (
        .clk (clk),
        .rst (rst_n),
        .bus (busS)
    );

    seq_match_counter #(
        .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W), .SATURATE(1'b0)
    ) dutWrap (
        .clk (clk),
        .rst (rst_n),
        .bus (busW)
    );

    // 40 ns period clock.
    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit hist[$];
    bit matchM;
    int cntS;
    int cntW;

    function automatic int histValue();
        int v = 0;
        for (int i = 0; i < hist.size(); i++) v = (v << 1) | int'(hist[i]);
        return v;
    endfunction

    task automatic modelReset();
        hist.delete();
        matchM = 1'b0;
        cntS   = 0;
        cntW   = 0;
    endtask

    task automatic modelStep(input bit e, input bit xx, input bit ov, input bit c);
        bit hit = 1'b0;
        if (e) begin
            hist.push_back(xx);
            if (hist.size() > PAT_W) void'(hist.pop_front());
            hit = (hist.size() == PAT_W) && (histValue() == int'(PATTERN));
            if (hit && !ov) hist.delete();
        end
        matchM = hit;
        if (c) begin
            cntS = hit ? 1 : 0;
            cntW = hit ? 1 : 0;
        end else if (hit) begin
            cntS = (cntS == CNT_MAX) ? CNT_MAX : cntS + 1;
            cntW = (cntW + 1) % (CNT_MAX + 1);
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".match"}, 32'(busS.match), 32'(matchM));
        checkVal({tag, ".ySat"},  32'(busS.y),     cntS);
        checkVal({tag, ".fill"},  32'(busS.fill),  hist.size());
        checkVal({tag, ".yWrap"}, 32'(busW.y),     cntW);
        checkVal({tag, ".matchW"}, 32'(busW.match), 32'(matchM));
    endtask

    task automatic driveInputs(input bit e, input bit xx, input bit ov, input bit c);
        busS.en = e;  busS.x = xx;  busS.overlap = ov;  busS.clr = c;
        busW.en = e;  busW.x = xx;  busW.overlap = ov;  busW.clr = c;
    endtask

    // One clock: inputs change mid-low phase, outputs checked 1 ns after the edge.
    task automatic applyStimulus(input string tag, input bit e, input bit xx, input bit ov, input bit c);
        @(negedge clk);
        #10 driveInputs(e, xx, ov, c);
        @(posedge clk);
        modelStep(e, xx, ov, c);
        #1 checkOutput(tag);
    endtask

    task automatic sendBits(input string tag, input logic [15:0] bits, input int n, input bit e, input bit ov);
        for (int i = n - 1; i >= 0; i--) applyStimulus(tag, e, bits[i], ov, 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge.
    task automatic asyncReset(input string tag);
        @(negedge clk);
        #10 driveInputs(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1 modelReset();
        checkOutput({tag, ".async"});
        @(posedge clk);
        #1 checkOutput({tag, ".held"});
        @(negedge clk);
        #5 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        driveInputs(1'b0, 1'b0, 1'b0, 1'b0);
        modelReset();
        #5 checkOutput("reset");
        @(negedge clk);
        #5 rst_n = 1'b1;

        // Basic detection.
        asyncReset("basicRst");
        sendBits("basic", 16'b1011, 4, 1'b1, 1'b1);
        checkVal("basic.matchConst", 32'(busS.match), 1);
        checkVal("basic.yConst",     32'(busS.y),     1);
        checkVal("basic.fillConst",  32'(busS.fill),  4);

        // Overlapping matches share the trailing 1.
        asyncReset("ovRst");
        sendBits("overlap", 16'b1011011, 7, 1'b1, 1'b1);
        checkVal("overlap.yConst", 32'(busS.y), 2);

        // Non-overlapping: fill restarts after a hit.
        asyncReset("novRst");
        sendBits("nonov", 16'b1011, 4, 1'b1, 1'b0);
        checkVal("nonov.fill4", 32'(busS.fill), 0);
        sendBits("nonov", 16'b011, 3, 1'b1, 1'b0);
        checkVal("nonov.fill7", 32'(busS.fill), 3);
        checkVal("nonov.yConst", 32'(busS.y), 1);

        // Nine hits: saturating copy sticks at 7, wrapping copy reads 1.
        asyncReset("satRst");
        sendBits("sat", 16'b1011, 4, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) sendBits("sat", 16'b011, 3, 1'b1, 1'b1);
        checkVal("sat.ySatConst",  32'(busS.y), 7);
        checkVal("sat.yWrapConst", 32'(busW.y), 1);

        // Bits presented while disabled are ignored.
        asyncReset("enRst");
        sendBits("en", 16'b10, 2, 1'b1, 1'b1);
        sendBits("enOff", 16'b000, 3, 1'b0, 1'b1);
        sendBits("en", 16'b11, 2, 1'b1, 1'b1);
        checkVal("en.matchConst", 32'(busS.match), 1);
        checkVal("en.yConst",     32'(busS.y),     1);

        // Reset mid-stream discards partial history.
        asyncReset("midRst0");
        sendBits("mid", 16'b1011, 4, 1'b1, 1'b1);
        sendBits("mid", 16'b101, 3, 1'b1, 1'b1);
        asyncReset("midRst");
        checkVal("mid.yZero",    32'(busS.y),    0);
        checkVal("mid.fillZero", 32'(busS.fill), 0);
        sendBits("midAfter", 16'b1, 1, 1'b1, 1'b1);
        checkVal("midAfter.noMatch", 32'(busS.match), 0);

        // Clear coinciding with a hit counts that hit.
        asyncReset("clrRst");
        sendBits("clr", 16'b1011, 4, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) sendBits("clr", 16'b011, 3, 1'b1, 1'b1);
        checkVal("clr.y5", 32'(busS.y), 5);
        sendBits("clr", 16'b01, 2, 1'b1, 1'b1);
        applyStimulus("clrHit", 1'b1, 1'b1, 1'b1, 1'b1);
        checkVal("clrHit.yConst",     32'(busS.y),     1);
        checkVal("clrHit.matchConst", 32'(busS.match), 1);

        // Randomized traffic with occasional clears and asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                asyncReset("randRst");
            end else begin
                applyStimulus("rand",
                              $urandom_range(0, 3) != 0,
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 15) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
